// File: rtl/step_motor_arbiter.sv
// Purpose : round-robin arbiter handing one stepper motor to one of two requesters per move.
// Latency : grant one clock after req seen in IDLE; grant-to-grant >= steps + SETTLE_CYCLES + 3.
// Backpressure: requests are level-held; a loser simply waits, changes after grant are ignored.
// Ports   : clk, reset (async, active-high); req/req_dir/req_steps0/req_steps1 request side;
//           step_tick from driver; motor_en/motor_dir/motor_steps to driver;
//           grant/busy/done/fault status.
// Option  : define STEP_TIMEOUT_EN to build the RUN-state step watchdog (TIMEOUT_CYCLES).
module step_motor_arbiter #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  req_dir,
    input  logic [13:0] req_steps0,
    input  logic [13:0] req_steps1,
    input  logic        step_tick,
    output logic        motor_en,
    output logic        motor_dir,
    output logic [13:0] motor_steps,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [1:0]  done,
    output logic        fault
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SETTLE, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;      // 1 = requester 1 was served last
    logic          dir_q, dir_d;
    logic [13:0]   steps_q, steps_d;
    logic [13:0]   cnt_q, cnt_d;
    logic [SW-1:0] set_q, set_d;
    logic          timeout_hit;

    // Winner is requester 1 when it asks alone, or when both ask and 0 went last.
    logic          pick1;
    logic [13:0]   win_steps;
    assign pick1     = req[1] & (~req[0] | ~last_q);
    assign win_steps = pick1 ? req_steps1 : req_steps0;

`ifdef STEP_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wd_q, wd_d;
`else
    // Parameter kept so both builds share one instantiation interface.
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            dir_q   <= 1'b0;
            steps_q <= 14'd0;
            cnt_q   <= 14'd0;
            set_q   <= '0;
`ifdef STEP_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            dir_q   <= dir_d;
            steps_q <= steps_d;
            cnt_q   <= cnt_d;
            set_q   <= set_d;
`ifdef STEP_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        dir_d       = dir_q;
        steps_d     = steps_q;
        cnt_d       = cnt_q;
        set_d       = set_q;
        timeout_hit = 1'b0;
`ifdef STEP_TIMEOUT_EN
        wd_d        = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    last_d  = pick1;
                    dir_d   = req_dir[pick1];
                    steps_d = win_steps;
                    cnt_d   = 14'd0;
                    set_d   = '0;
`ifdef STEP_TIMEOUT_EN
                    wd_d    = '0;
`endif
                    // A zero-length move never enables the driver.
                    state_d = (win_steps == 14'd0) ? S_SETTLE : S_RUN;
                end
            end
            S_RUN: begin
                // Compare on the registered count: the final tick is seen one clock
                // before leaving RUN, and later ticks are not counted.
                if (cnt_q == steps_q) begin
                    state_d = S_SETTLE;
                    set_d   = '0;
                end else if (step_tick) begin
                    cnt_d = cnt_q + 14'd1;
`ifdef STEP_TIMEOUT_EN
                    wd_d  = '0;
`endif
                end else begin
`ifdef STEP_TIMEOUT_EN
                    if (wd_q == WD_LAST) begin
                        timeout_hit = 1'b1;
                        state_d     = S_SETTLE;
                        set_d       = '0;
                    end else begin
                        wd_d = wd_q + WW'(1);
                    end
`endif
                end
            end
            S_SETTLE: begin
                if (set_q == SETTLE_LAST) begin
                    state_d = S_DONE;
                end else begin
                    set_d = set_q + SW'(1);
                end
            end
            S_DONE: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        motor_en    = (state_q == S_RUN);
        motor_dir   = dir_q;
        motor_steps = steps_q;
        grant       = grant_q;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE) ? grant_q : 2'b00;
        fault       = timeout_hit;
    end

endmodule

// File: tb/tb_step_motor_arbiter.sv
`timescale 1ns/1ps
module tb_step_motor_arbiter;

    localparam int SETTLE = 16;
    localparam int TMO    = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  req_dir;
    logic [13:0] req_steps0;
    logic [13:0] req_steps1;
    logic        step_tick;
    logic        motor_en;
    logic        motor_dir;
    logic [13:0] motor_steps;
    logic [1:0]  grant;
    logic        busy;
    logic [1:0]  done;
    logic        fault;

    always #5 clk = ~clk;

    step_motor_arbiter #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_dir(req_dir),
        .req_steps0(req_steps0), .req_steps1(req_steps1), .step_tick(step_tick),
        .motor_en(motor_en), .motor_dir(motor_dir), .motor_steps(motor_steps),
        .grant(grant), .busy(busy), .done(done), .fault(fault)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc_n  = 0;
    int fault_cnt = 0;
    int fault_exp = 0;

    logic [16:0] exp_grant_q [$];   // {grant, motor_dir, motor_steps}
    logic [1:0]  exp_done_q  [$];
    logic [1:0]  prev_grant = 2'b00;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    always @(posedge clk) cyc_n++;

    // Scoreboard monitor: grant rise and done pulses pop expectations.
    always @(negedge clk) begin
        if (grant == 2'b11) check("grant_onehot", {30'd0, grant}, 32'd0);
        if (prev_grant == 2'b00 && grant != 2'b00) begin
            if (exp_grant_q.size() == 0) check("grant_unexpected", {15'd0, grant, motor_dir, motor_steps}, 32'd0);
            else check("grant_evt", {15'd0, grant, motor_dir, motor_steps}, {15'd0, exp_grant_q.pop_front()});
        end
        if (done != 2'b00) begin
            if (exp_done_q.size() == 0) check("done_unexpected", {30'd0, done}, 32'd0);
            else check("done_evt", {30'd0, done}, {30'd0, exp_done_q.pop_front()});
        end
        if (fault) fault_cnt++;
        prev_grant = grant;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(output int t);
        int b = 0;
        while (grant == 2'b00 && b < 2000) begin @(negedge clk); b++; end
        if (b >= 2000) check("grant_wait_expired", b, 0);
        t = cyc_n;
    endtask

    task automatic wait_done();
        int b = 0;
        while (done == 2'b00 && b < 5000) begin @(negedge clk); b++; end
        if (b >= 5000) check("done_wait_expired", b, 0);
    endtask

    task automatic run_ticks();
        int b = 0;
        while (motor_en && b < 20000) begin step_tick = 1'b1; @(negedge clk); b++; end
        step_tick = 1'b0;
        if (b >= 20000) check("tick_budget_expired", b, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, g_t[3], n;
        logic en_seen;
        reset = 1'b1; req = 2'b00; req_dir = 2'b00;
        req_steps0 = 14'd0; req_steps1 = 14'd0; step_tick = 1'b0;
        cyc(3);
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_motor_en", {31'd0, motor_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {30'd0, done}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_motor_steps", {18'd0, motor_steps}, 32'd0);
        check("rst_motor_dir", {31'd0, motor_dir}, 32'd0);
        reset = 1'b0;
        cyc(2);

        // Ticks while idle must not start or pre-load a move.
        step_tick = 1'b1; cyc(3); step_tick = 1'b0; cyc(1);
        check("idle_tick_busy", {31'd0, busy}, 32'd0);

        // Single forward move of 3 steps; req and steps change after grant.
        exp_grant_q.push_back({2'b01, 1'b1, 14'd3});
        exp_done_q.push_back(2'b01);
        req = 2'b01; req_dir = 2'b01; req_steps0 = 14'd3;
        wait_grant(t0);
        req = 2'b00; req_steps0 = 14'd77;
        check("t1_en_start", {31'd0, motor_en}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step_tick = 1'b1; cyc(1); step_tick = 1'b0; cyc(2);
            if (i < 2) check("t1_en_mid", {31'd0, motor_en}, 32'd1);
        end
        check("t1_en_after_last", {31'd0, motor_en}, 32'd0);
        check("t1_steps_latched", {18'd0, motor_steps}, 32'd3);
        step_tick = 1'b1; cyc(2); step_tick = 1'b0;   // ticks during settle
        wait_done();
        cyc(2);
        check("t1_idle_after_done", {31'd0, busy}, 32'd0);

        // Contention from reset: 0, then 1, then 0 again.
        reset = 1'b1; cyc(2); reset = 1'b0; cyc(1);
        exp_grant_q.push_back({2'b01, 1'b0, 14'd2});
        exp_grant_q.push_back({2'b10, 1'b1, 14'd5});
        exp_grant_q.push_back({2'b01, 1'b0, 14'd2});
        exp_done_q.push_back(2'b01);
        exp_done_q.push_back(2'b10);
        exp_done_q.push_back(2'b01);
        req_dir = 2'b10; req_steps0 = 14'd2; req_steps1 = 14'd5; req = 2'b11;
        for (int m = 0; m < 3; m++) begin
            wait_grant(g_t[m]);
            if (m == 2) req = 2'b00;
            run_ticks();
            wait_done();
            cyc(1);
        end
        check("t2_spacing_a", g_t[1] - g_t[0], 2 + SETTLE + 3);
        check("t2_spacing_b", g_t[2] - g_t[1], 5 + SETTLE + 3);
        cyc(2);

        // Zero-step move: no enable, done 18 clocks after req.
        exp_grant_q.push_back({2'b10, 1'b1, 14'd0});
        exp_done_q.push_back(2'b10);
        req_steps1 = 14'd0; req = 2'b10;
        n = 1; en_seen = 1'b0;
        while (done == 2'b00 && n < 200) begin
            @(negedge clk); n++;
            if (motor_en) en_seen = 1'b1;
            if (grant != 2'b00) req = 2'b00;
        end
        check("t3_done_clock", n, 18);
        check("t3_en_never", {31'd0, en_seen}, 32'd0);
        cyc(3);

        // Reset mid-move: outputs drop at once, no done, next request served.
        exp_grant_q.push_back({2'b01, 1'b1, 14'd200});
        req_dir = 2'b01; req_steps0 = 14'd200; req = 2'b01;
        wait_grant(t0);
        req = 2'b00;
        step_tick = 1'b1; cyc(50); step_tick = 1'b0;
        check("t4_en_before_rst", {31'd0, motor_en}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t4_rst_motor_en", {31'd0, motor_en}, 32'd0);
        check("t4_rst_grant", {30'd0, grant}, 32'd0);
        check("t4_rst_busy", {31'd0, busy}, 32'd0);
        check("t4_rst_steps", {18'd0, motor_steps}, 32'd0);
        check("t4_rst_done", {30'd0, done}, 32'd0);
        cyc(2); reset = 1'b0; cyc(2);
        exp_grant_q.push_back({2'b10, 1'b0, 14'd1});
        exp_done_q.push_back(2'b10);
        req_steps1 = 14'd1; req = 2'b10;
        wait_grant(t0);
        req = 2'b00;
        run_ticks();
        wait_done();
        cyc(2);

`ifdef STEP_TIMEOUT_EN
        // Watchdog: no ticks -> fault on RUN clock TMO; a tick on that clock wins.
        exp_grant_q.push_back({2'b01, 1'b1, 14'd5});
        exp_done_q.push_back(2'b01);
        req_steps0 = 14'd5; req = 2'b01;
        wait_grant(t0);
        req = 2'b00;
        n = 1;
        while (!fault && n < 300) begin @(negedge clk); n++; end
        check("t5_fault_clock", n, TMO);
        fault_exp++;
        wait_done();
        cyc(2);
        exp_grant_q.push_back({2'b01, 1'b1, 14'd5});
        exp_done_q.push_back(2'b01);
        req = 2'b01;
        wait_grant(t0);
        req = 2'b00;
        n = 1;
        while (n < TMO - 1) begin @(negedge clk); n++; end
        @(posedge clk); #1 step_tick = 1'b1;
        @(posedge clk); #1 step_tick = 1'b0;
        @(negedge clk);
        check("t5_tick_wins_en", {31'd0, motor_en}, 32'd1);
        run_ticks();
        wait_done();
        cyc(2);
`endif

        check("end_grant_queue", exp_grant_q.size(), 0);
        check("end_done_queue", exp_done_q.size(), 0);
        check("fault_count", fault_cnt, fault_exp);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
